// File: rtl/shiftreg_ctrl_pkg.sv
// Shared definitions for the shift register sequencer: state encoding,
// job mode constants and the SHIFT exit decision.
package shiftreg_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic MODE_TX = 1'b0;
    localparam logic MODE_RX = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_SHIFT   = ST_SHIFT,
        S_CAPTURE = ST_CAPTURE,
        S_DONE    = ST_DONE
    } state_t;

    // RX jobs still need the parallel capture; TX jobs are finished.
    function automatic state_t shift_exit_state(input logic mode);
        if (mode == MODE_RX) begin
            return S_CAPTURE;
        end else begin
            return S_DONE;
        end
    endfunction

endpackage

// File: rtl/shiftreg_ctrl_if.sv
// Bus-side handshake and shift register control signals of the sequencer.
// The slave modport is the controller's view, the master modport the driver's.
interface shiftreg_ctrl_if #(
    parameter int SIZE = 8
);
    logic            Start;
    logic            Mode;
    logic            Abort;
    logic [SIZE-1:0] TxData;
    logic [SIZE-1:0] SrDataOut;
    logic            Ready;
    logic            Busy;
    logic            SrLoad;
    logic            SrEn;
    logic [SIZE-1:0] SrDataIn;
    logic [SIZE-1:0] RxData;
    logic            Done;

    modport slave (
        input  Start, Mode, Abort, TxData, SrDataOut,
        output Ready, Busy, SrLoad, SrEn, SrDataIn, RxData, Done
    );

    modport master (
        output Start, Mode, Abort, TxData, SrDataOut,
        input  Ready, Busy, SrLoad, SrEn, SrDataIn, RxData, Done
    );
endinterface

// File: rtl/shiftreg_ctrl_bit_timer.sv
// Bit period divider: counts 0..DIV-1 while Run is high and flags the last
// cycle of each period as the shift strobe.
module bit_timer #(
    parameter int DIV   = 1,
    parameter int CNT_W = 8
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clr,
    input  logic Run,
    output logic Strobe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    // Next divider count: clear, wrap at the period end, or advance.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (Clr) begin
            div_cnt_d = {CNT_W{1'b0}};
        end else if (Run) begin
            if (div_cnt_q == CNT_LAST) begin
                div_cnt_d = {CNT_W{1'b0}};
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Divider count register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div_cnt_q <= {CNT_W{1'b0}};
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Only compared against DIV-1, so a DIV of 1 keeps the strobe high.
    assign Strobe = Run && (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/shiftreg_ctrl.sv
// Sequencer for an 8-bit non-cyclic shift register: TX loads and shifts a
// word out, RX shifts a word in and captures it. Outputs decode registered state.
module shiftreg_ctrl
    import shiftreg_ctrl_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DIV   = 1,
    parameter int CNT_W = 8
) (
    input logic           Clk,
    input logic           Rst,
    shiftreg_ctrl_if.slave bus
);

    localparam int              BIT_W    = $clog2(SIZE + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SIZE - 1);

    state_t            state_q;
    state_t            state_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic [SIZE-1:0]   data_q;
    logic [SIZE-1:0]   data_d;
    logic              mode_q;
    logic              mode_d;
    logic [SIZE-1:0]   rx_data_q;
    logic [SIZE-1:0]   rx_data_d;
    logic              strobe;
    logic              timer_clr;
    logic              timer_run;

    // Divider runs only in SHIFT and restarts from zero on each entry.
    assign timer_run = (state_q == S_SHIFT);
    assign timer_clr = (state_q != S_SHIFT);

    bit_timer #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clr    (timer_clr),
        .Run    (timer_run),
        .Strobe (strobe)
    );

    // Next-state logic; Abort overrides everything, including a Start in IDLE.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        mode_d    = mode_q;
        rx_data_d = rx_data_q;
        if (bus.Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        data_d    = bus.TxData;
                        mode_d    = bus.Mode;
                        bit_cnt_d = {BIT_W{1'b0}};
                        if (bus.Mode == MODE_RX) begin
                            state_d = S_SHIFT;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (strobe) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = shift_exit_state(mode_q);
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
                S_CAPTURE: begin
                    rx_data_d = bus.SrDataOut;
                    state_d   = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter and data registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= {BIT_W{1'b0}};
            data_q    <= {SIZE{1'b0}};
            mode_q    <= MODE_TX;
            rx_data_q <= {SIZE{1'b0}};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign bus.Ready    = (state_q == S_IDLE);
    assign bus.Busy     = (state_q != S_IDLE);
    assign bus.SrLoad   = (state_q == S_LOAD);
    assign bus.SrEn     = strobe;
    assign bus.SrDataIn = (state_q == S_LOAD) ? data_q : {SIZE{1'b0}};
    assign bus.RxData   = rx_data_q;
    assign bus.Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Directed bench for shiftreg_ctrl with DIV=1 and DIV=4 instances, each wired
// to a small MSB-first shift register model.
module tb_shiftreg_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    shiftreg_ctrl_if #(.SIZE(8)) if1 ();
    shiftreg_ctrl_if #(.SIZE(8)) if4 ();

    shiftreg_ctrl #(.SIZE(8), .DIV(1), .CNT_W(8)) dut1 (.Clk(clk), .Rst(rst), .bus(if1.slave));
    shiftreg_ctrl #(.SIZE(8), .DIV(4), .CNT_W(8)) dut4 (.Clk(clk), .Rst(rst), .bus(if4.slave));

    logic [7:0] sr1;
    logic [7:0] sr4;
    int         cnt1;
    int         cnt4;
    logic [7:0] rx_word1;
    logic       ser_in1;

    assign ser_in1       = (cnt1 < 8) ? rx_word1[7 - cnt1] : 1'b0;
    assign if1.SrDataOut = sr1;
    assign if4.SrDataOut = sr4;

    // Shift register models; strobe counters restart whenever the DUT is idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sr1 <= 8'h00; sr4 <= 8'h00; cnt1 <= 0; cnt4 <= 0;
        end else begin
            if (if1.SrLoad) sr1 <= if1.SrDataIn;
            else if (if1.SrEn) sr1 <= {sr1[6:0], ser_in1};
            if (if4.SrLoad) sr4 <= if4.SrDataIn;
            else if (if4.SrEn) sr4 <= {sr4[6:0], 1'b0};
            if (if1.Ready) cnt1 <= 0;
            else if (if1.SrEn) cnt1 <= cnt1 + 1;
            if (if4.Ready) cnt4 <= 0;
            else if (if4.SrEn) cnt4 <= cnt4 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_ready"}, if1.Ready, 1'b1);
        chk({tag, "_busy"}, if1.Busy, 1'b0);
        chk({tag, "_load"}, if1.SrLoad, 1'b0);
        chk({tag, "_en"}, if1.SrEn, 1'b0);
        chk({tag, "_din"}, if1.SrDataIn, 8'h00);
        chk({tag, "_done"}, if1.Done, 1'b0);
        chk({tag, "_rx"}, if1.RxData, 8'h00);
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1;
        if1.Start = 1'b0; if1.Mode = 1'b0; if1.Abort = 1'b0; if1.TxData = 8'h00;
        if4.Start = 1'b0; if4.Mode = 1'b0; if4.Abort = 1'b0; if4.TxData = 8'h00;
        rx_word1 = 8'h00;
        #1;
        chk_reset1("init");
        chk("init4_ready", if4.Ready, 1'b1);
        tick(); tick();
        rst = 1'b0;
        tick();

        // TX 0xAA, DIV=1: LOAD cycle 1, strobes 2..9, Done 10, Ready 11
        w = 8'hAA;
        if1.TxData = w; if1.Mode = 1'b0; if1.Start = 1'b1;
        tick();
        if1.Start = 1'b0; if1.TxData = 8'h00;
        chk("tx_load", if1.SrLoad, 1'b1);
        chk("tx_din", if1.SrDataIn, 8'hAA);
        chk("tx_en_c1", if1.SrEn, 1'b0);
        chk("tx_busy", if1.Busy, 1'b1);
        for (int c = 2; c <= 9; c++) begin
            tick();
            chk("tx_en", if1.SrEn, 1'b1);
            chk("tx_load0", if1.SrLoad, 1'b0);
            chk("tx_din0", if1.SrDataIn, 8'h00);
            chk("tx_serout", sr1[7], w[9 - c]);
        end
        tick();
        chk("tx_done", if1.Done, 1'b1);
        chk("tx_notready", if1.Ready, 1'b0);
        chk("tx_en_done", if1.SrEn, 1'b0);
        chk("tx_strobes", cnt1, 8);
        tick();
        chk("tx_ready", if1.Ready, 1'b1);
        chk("tx_done_once", if1.Done, 1'b0);

        // RX 0xAA, DIV=1: strobes 1..8, CAPTURE 9, Done 10
        rx_word1 = 8'hAA;
        if1.Mode = 1'b1; if1.Start = 1'b1;
        tick();
        if1.Start = 1'b0; if1.Mode = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("rx_en", if1.SrEn, 1'b1);
            chk("rx_noload", if1.SrLoad, 1'b0);
            tick();
        end
        chk("rx_cap_en", if1.SrEn, 1'b0);
        chk("rx_cap_busy", if1.Busy, 1'b1);
        chk("rx_cap_done", if1.Done, 1'b0);
        tick();
        chk("rx_done", if1.Done, 1'b1);
        chk("rx_data", if1.RxData, 8'hAA);
        chk("rx_noload_done", if1.SrLoad, 1'b0);
        tick();
        chk("rx_ready", if1.Ready, 1'b1);

        // Abort an RX job after three strobes
        rx_word1 = 8'hC3;
        if1.Mode = 1'b1; if1.Start = 1'b1;
        tick();
        if1.Start = 1'b0;
        tick(); tick(); tick();
        chk("ab_en_c4", if1.SrEn, 1'b1);
        if1.Abort = 1'b1;
        tick();
        if1.Abort = 1'b0;
        chk("ab_ready", if1.Ready, 1'b1);
        chk("ab_busy", if1.Busy, 1'b0);
        chk("ab_en", if1.SrEn, 1'b0);
        chk("ab_done", if1.Done, 1'b0);
        chk("ab_rx_keep", if1.RxData, 8'hAA);
        tick();
        chk("ab_done_later", if1.Done, 1'b0);
        chk("ab_rx_keep2", if1.RxData, 8'hAA);

        // Following RX of 0x3C
        rx_word1 = 8'h3C;
        if1.Mode = 1'b1; if1.Start = 1'b1;
        tick();
        if1.Start = 1'b0;
        repeat (9) tick();
        chk("rx2_done", if1.Done, 1'b1);
        chk("rx2_data", if1.RxData, 8'h3C);
        chk("rx2_strobes", cnt1, 8);
        tick();

        // Start together with Abort in IDLE: Start is dropped
        if1.Mode = 1'b0; if1.TxData = 8'hFF; if1.Start = 1'b1; if1.Abort = 1'b1;
        tick();
        if1.Start = 1'b0; if1.Abort = 1'b0;
        chk("sa_ready", if1.Ready, 1'b1);
        chk("sa_load", if1.SrLoad, 1'b0);
        tick();
        chk("sa_ready2", if1.Ready, 1'b1);

        // Start held high through a TX job with changing TxData
        w = 8'h81;
        if1.Mode = 1'b0; if1.TxData = w; if1.Start = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            if1.TxData = 8'h10 + 8'(c);
            chk("sb_overlap", if1.SrLoad & if1.SrEn, 1'b0);
            if (c == 1) begin
                chk("sb_load", if1.SrLoad, 1'b1);
                chk("sb_din", if1.SrDataIn, 8'h81);
            end else if (c <= 9) begin
                chk("sb_en", if1.SrEn, 1'b1);
                chk("sb_noload", if1.SrLoad, 1'b0);
                chk("sb_serout", sr1[7], w[9 - c]);
            end else if (c == 10) begin
                chk("sb_done", if1.Done, 1'b1);
            end else begin
                chk("sb_ready", if1.Ready, 1'b1);
            end
            tick();
        end
        chk("sb2_load", if1.SrLoad, 1'b1);
        chk("sb2_din", if1.SrDataIn, 8'h1B);
        if1.Start = 1'b0; if1.Abort = 1'b1;
        tick();
        if1.Abort = 1'b0;
        chk("sb2_ab_ready", if1.Ready, 1'b1);
        chk("sb2_ab_load", if1.SrLoad, 1'b0);
        chk("sb2_ab_done", if1.Done, 1'b0);

        // Reset asserted mid-TX clears everything at once, including RxData
        if1.TxData = 8'hF0; if1.Mode = 1'b0; if1.Start = 1'b1;
        tick();
        if1.Start = 1'b0;
        tick(); tick();
        chk("mr_en_before", if1.SrEn, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_reset1("mr");
        tick(); tick(); tick();
        chk_reset1("mr_hold");
        rst = 1'b0;
        tick();

        // TX 0x5A with DIV=4: strobes at cycles 5,9,...,33, Done 34, Ready 35
        w = 8'h5A;
        if4.TxData = w; if4.Mode = 1'b0; if4.Start = 1'b1;
        tick();
        if4.Start = 1'b0;
        chk("d4_load", if4.SrLoad, 1'b1);
        chk("d4_din", if4.SrDataIn, 8'h5A);
        for (int c = 2; c <= 33; c++) begin
            tick();
            chk("d4_en", if4.SrEn, ((c - 2) % 4 == 3) ? 1'b1 : 1'b0);
            if ((c - 2) % 4 == 3) begin
                chk("d4_serout", sr4[7], w[7 - (c - 2) / 4]);
            end
        end
        tick();
        chk("d4_done", if4.Done, 1'b1);
        chk("d4_strobes", cnt4, 8);
        tick();
        chk("d4_ready", if4.Ready, 1'b1);
        chk("d4_done_once", if4.Done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
